// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one unsigned SIZE x SIZE multiplier among
// NREQ valid/ready requesters, with a single-entry response register.
module mul_share_arb #(
   parameter int SIZE = 4,
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*SIZE-1:0] req_a,
   input  logic [NREQ*SIZE-1:0] req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [2*SIZE-1:0]    rsp_y,
   output logic [IDW-1:0]       rsp_id,
   output logic [15:0]          txn_cnt
);

   logic                rsp_valid_q, rsp_valid_d;
   logic [2*SIZE-1:0]   rsp_y_q, rsp_y_d;
   logic [IDW-1:0]      rsp_id_q, rsp_id_d;
   logic [IDW-1:0]      last_q, last_d;
   logic [15:0]         txn_cnt_q, txn_cnt_d;

   logic                slot_free;
   logic                gnt_found;
   logic [IDW-1:0]      gnt_idx;
   logic [NREQ-1:0]     gnt_vec;
   logic                xfer;
   logic [SIZE-1:0]     a_sel, b_sel;
   logic [2*SIZE-1:0]   prod;
   int                  idx;

   // Search starts one past the last winner and wraps.
   always_comb begin
      slot_free = !rsp_valid_q || rsp_ready;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_q) + k) % NREQ;
         for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && i == idx && req_valid[i]) begin
               gnt_found = 1'b1;
               gnt_idx   = IDW'(i);
            end
         end
      end
   end

   always_comb begin
      gnt_vec = '0;
      a_sel   = '0;
      b_sel   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            gnt_vec[i] = gnt_found && slot_free && !rst;
            a_sel      = req_a[i*SIZE +: SIZE];
            b_sel      = req_b[i*SIZE +: SIZE];
         end
      end
      xfer = |gnt_vec;
      prod = (2*SIZE)'(a_sel) * (2*SIZE)'(b_sel);
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_y_d     = rsp_y_q;
      rsp_id_d    = rsp_id_q;
      last_d      = last_q;
      txn_cnt_d   = txn_cnt_q;
      if (xfer) begin
         rsp_valid_d = 1'b1;
         rsp_y_d     = prod;
         rsp_id_d    = gnt_idx;
         last_d      = gnt_idx;
         txn_cnt_d   = txn_cnt_q + 16'd1;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_y_q     <= '0;
         rsp_id_q    <= '0;
         last_q      <= IDW'(NREQ - 1);
         txn_cnt_q   <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_y_q     <= rsp_y_d;
         rsp_id_q    <= rsp_id_d;
         last_q      <= last_d;
         txn_cnt_q   <= txn_cnt_d;
      end
   end

   assign req_ready = gnt_vec;
   assign rsp_valid = rsp_valid_q;
   assign rsp_y     = rsp_y_q;
   assign rsp_id    = rsp_id_q;
   assign txn_cnt   = txn_cnt_q;

endmodule
